// File: rtl/mio_pkg.sv
// mio_pkg: definitions shared by the memory-mapped I/O bus blocks.
//   dma_state_t : state encoding of the mio_dma bus-master FSM
//   ADDR_STEP   : byte stride between consecutive 32-bit words
//   RAM/LG/SEG/IO : address-map region codes (address bits [31:28])
//   step_addr() : advance an address by one word when incrementing is enabled

package mio_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } dma_state_t;

    localparam logic [31:0] ADDR_STEP = 32'd4;

    localparam logic [3:0] RAM = 4'h0;
    localparam logic [3:0] LG  = 4'hd;
    localparam logic [3:0] SEG = 4'he;
    localparam logic [3:0] IO  = 4'hf;

    // Wraps modulo 2^32, so 0xFFFFFFFC steps to 0.
    function automatic logic [31:0] step_addr(input logic [31:0] addr, input logic inc);
        return inc ? addr + ADDR_STEP : addr;
    endfunction

endpackage

// File: rtl/mio_dma.sv
// mio_dma: single-channel bus master that copies `len` 32-bit words from a
// source address to a destination address using ordinary read/write cycles.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : launch pulse, accepted only when idle
//   src_addr, dst_addr    : first source / destination byte addresses
//   len                   : number of words to copy
//   src_inc, dst_inc      : advance the respective address by 4 after each word
//   busy, done, err       : status; done and err are one-cycle pulses
//   bus_req, bus_gnt      : arbiter handshake
//   mem_w, addr_bus,
//   data2bus, data4bus    : bus cycle signals toward the decoder
//
// RD_LAT (1..3) is the number of cycles a read address is held before the
// returned data is sampled.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// REQ   | requesting the bus, waiting for grant
// RD    | read cycle on the current source address, RD_LAT cycles long
// WR    | one write cycle to the current destination, advance pointers
// DONE  | one-cycle completion (err flags a rejected misaligned start)

module mio_dma
    import mio_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [7:0]  len,
    input  logic        src_inc,
    input  logic        dst_inc,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        mem_w,
    output logic [31:0] addr_bus,
    output logic [31:0] data2bus,
    input  logic [31:0] data4bus
);

    // Read-latency timer loads RD_LAT-1 and the data is sampled when it hits 0.
    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    dma_state_t  state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  lat_q, lat_d;
    logic [31:0] buf_q, buf_d;
    logic        src_inc_q, src_inc_d;
    logic        dst_inc_q, dst_inc_d;
    logic        err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            cnt_q     <= '0;
            lat_q     <= '0;
            buf_q     <= '0;
            src_inc_q <= 1'b0;
            dst_inc_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            buf_q     <= buf_d;
            src_inc_q <= src_inc_d;
            dst_inc_q <= dst_inc_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        buf_d     = buf_q;
        src_inc_d = src_inc_q;
        dst_inc_d = dst_inc_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((src_addr[1:0] | dst_addr[1:0]) != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (len == 8'd0) begin
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        src_d     = src_addr;
                        dst_d     = dst_addr;
                        cnt_d     = len;
                        src_inc_d = src_inc;
                        dst_inc_d = dst_inc;
                        err_d     = 1'b0;
                        state_d   = REQ;
                    end
                end
            end

            REQ: begin
                if (bus_gnt) begin
                    lat_d   = LAT_LOAD;
                    state_d = RD;
                end
            end

            RD: begin
                if (lat_q == 2'd0) begin
                    buf_d   = data4bus;
                    state_d = WR;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end

            WR: begin
                cnt_d = cnt_q - 8'd1;
                src_d = step_addr(src_q, src_inc_q);
                dst_d = step_addr(dst_q, dst_inc_q);
                // cnt_q still holds the count before this word retires.
                if (cnt_q == 8'd1) begin
                    state_d = DONE;
                end else if (bus_gnt) begin
                    lat_d   = LAT_LOAD;
                    state_d = RD;
                end else begin
                    state_d = REQ;
                end
            end

            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus outputs are forced to 0 outside RD/WR so they can be ORed with the CPU.
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign err      = (state_q == DONE) && err_q;
    assign bus_req  = (state_q == REQ) || (state_q == RD) || (state_q == WR);
    assign mem_w    = (state_q == WR);
    assign addr_bus = (state_q == RD) ? src_q :
                      (state_q == WR) ? dst_q : 32'h0;
    assign data2bus = (state_q == WR) ? buf_q : 32'h0;

endmodule

// File: tb/tb_mio_dma.sv
module tb_mio_dma;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [7:0]  len = '0;
    logic        src_inc = 1'b0;
    logic        dst_inc = 1'b0;
    logic        bus_gnt = 1'b1;
    logic [31:0] data4bus = '0;
    logic        busy, done, err, bus_req, mem_w;
    logic [31:0] addr_bus, data2bus;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    bit req_seen = 0;
    int rd_cycles = 0;
    logic [31:0] prev_rd_addr = '0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] wq_a[$], wq_d[$], ex_a[$], ex_d[$];

    mio_dma #(.RD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .src_inc(src_inc), .dst_inc(dst_inc),
        .busy(busy), .done(done), .err(err),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .mem_w(mem_w),
        .addr_bus(addr_bus), .data2bus(data2bus), .data4bus(data4bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Bus slave: stores writes, logs them, and returns valid read data only
    // once an address has been held for LAT cycles (garbage before that).
    always @(negedge clk) begin
        if (rst_n && mem_w) begin
            mem[addr_bus] = data2bus;
            wq_a.push_back(addr_bus);
            wq_d.push_back(data2bus);
        end
        if (rst_n && done) done_cnt++;
        if (bus_req) req_seen = 1;
        if (bus_req && !mem_w && addr_bus != 32'h0) begin
            rd_cycles = (rd_cycles > 0 && addr_bus == prev_rd_addr) ? rd_cycles + 1 : 1;
            prev_rd_addr = addr_bus;
        end else begin
            rd_cycles = 0;
        end
        data4bus = (rd_cycles >= LAT) ? mem_rd(addr_bus) : (32'hBAD0_0000 ^ addr_bus);
    end

    // Expected writes are derived from the copy rule on a memory snapshot;
    // every test keeps source and destination disjoint.
    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [7:0] n,
                            input logic si, input logic di, input bit rg, input bit poke,
                            output int k, output int done_at, output logic err_at);
        ex_a.delete(); ex_d.delete(); wq_a.delete(); wq_d.delete();
        if ((s[1:0] | d[1:0]) == 2'b00) begin
            for (int i = 0; i < int'(n); i++) begin
                ex_a.push_back(d + (di ? 32'(4 * i) : 32'h0));
                ex_d.push_back(mem_rd(s + (si ? 32'(4 * i) : 32'h0)));
            end
        end
        @(negedge clk);
        src_addr = s; dst_addr = d; len = n; src_inc = si; dst_inc = di;
        start = 1'b1;
        k = cyc;
        req_seen = 0;
        @(negedge clk);
        start = 1'b0;
        done_at = -1;
        err_at = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (done) begin
                done_at = cyc;
                err_at = err;
                break;
            end
            if (poke && t == 2) begin
                src_addr = 32'h4; dst_addr = 32'h8; len = 8'd9; src_inc = 0; dst_inc = 0;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            // Grant may only change at a word boundary (WR) or while not reading.
            if (rg && (mem_w || !(bus_req && addr_bus != 32'h0)))
                bus_gnt = ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end
        start = 1'b0;
        bus_gnt = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", bus_req); end
        total++; if (mem_w !== 1'b0) begin bad++; $display("FAIL reset_memw: got %b want 0", mem_w); end
        total++; if (addr_bus !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", addr_bus); end
        total++; if (data2bus !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", data2bus); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int k, da; logic e;
        mem[32'h10] = 32'hAAAA_0001; mem[32'h14] = 32'hBBBB_0002; mem[32'h18] = 32'hCCCC_0003;
        run_xfer(32'h10, 32'h100, 8'd3, 1, 1, 0, 0, k, da, e);
        total++; if (da !== k + 2 + 3 * (LAT + 1)) begin bad++; $display("FAIL basic_done_cycle: got %0d want %0d", da - k, 2 + 3 * (LAT + 1)); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", e); end
        total++; if (mem_rd(32'h100) !== 32'hAAAA_0001) begin bad++; $display("FAIL basic_m100: got %h want aaaa0001", mem_rd(32'h100)); end
        total++; if (mem_rd(32'h104) !== 32'hBBBB_0002) begin bad++; $display("FAIL basic_m104: got %h want bbbb0002", mem_rd(32'h104)); end
        total++; if (mem_rd(32'h108) !== 32'hCCCC_0003) begin bad++; $display("FAIL basic_m108: got %h want cccc0003", mem_rd(32'h108)); end
        total++; if (wq_a.size() != 3) begin bad++; $display("FAIL basic_nwrites: got %0d want 3", wq_a.size()); end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_after_done: got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_len0();
        int k, da; logic e;
        run_xfer(32'h10, 32'h100, 8'd0, 1, 1, 0, 0, k, da, e);
        total++; if (da !== k + 1) begin bad++; $display("FAIL len0_done_cycle: got %0d want 1", da - k); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL len0_err: got %b want 0", e); end
        total++; if (req_seen !== 1'b0) begin bad++; $display("FAIL len0_req: got %b want 0", req_seen); end
        total++; if (wq_a.size() != 0) begin bad++; $display("FAIL len0_writes: got %0d want 0", wq_a.size()); end
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        int k, da; logic e;
        run_xfer(32'h12, 32'h100, 8'd3, 1, 1, 0, 0, k, da, e);
        total++; if (da !== k + 1) begin bad++; $display("FAIL misal_src_done_cycle: got %0d want 1", da - k); end
        total++; if (e !== 1'b1) begin bad++; $display("FAIL misal_src_err: got %b want 1", e); end
        total++; if (req_seen !== 1'b0 || wq_a.size() != 0) begin bad++; $display("FAIL misal_src_bus: got req=%b writes=%0d want 0 0", req_seen, wq_a.size()); end
        @(negedge clk);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL misal_err_pulse: got %b want 0", err); end
        run_xfer(32'h10, 32'h101, 8'd2, 1, 1, 0, 0, k, da, e);
        total++; if (da !== k + 1 || e !== 1'b1) begin bad++; $display("FAIL misal_dst: got cyc=%0d err=%b want 1 1", da - k, e); end
        total++; if (wq_a.size() != 0) begin bad++; $display("FAIL misal_dst_writes: got %0d want 0", wq_a.size()); end
        @(negedge clk);
    endtask

    task automatic test_fixed_dst();
        int k, da; logic e;
        for (int i = 0; i < 4; i++) mem[32'h40 + 32'(4 * i)] = 32'h5EC0_0000 + 32'(i * 17 + 3);
        run_xfer(32'h40, 32'hE000_0000, 8'd4, 1, 0, 0, 0, k, da, e);
        total++; if (wq_a.size() != 4) begin bad++; $display("FAIL fixed_nwrites: got %0d want 4", wq_a.size()); end
        for (int i = 0; i < 4 && i < wq_a.size(); i++) begin
            total++;
            if (wq_a[i] !== ex_a[i] || wq_d[i] !== ex_d[i]) begin
                bad++; $display("FAIL fixed_write%0d: got %h<=%h want %h<=%h", i, wq_a[i], wq_d[i], ex_a[i], ex_d[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_grant_drop();
        bit found = 0;
        int dc;
        mem[32'h20] = 32'h1234_5678; mem[32'h24] = 32'h9ABC_DEF0;
        wq_a.delete(); wq_d.delete();
        dc = done_cnt;
        @(negedge clk);
        src_addr = 32'h20; dst_addr = 32'h120; len = 8'd2; src_inc = 1; dst_inc = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (mem_w) begin found = 1; break; end
            @(negedge clk);
        end
        total++; if (!found) begin bad++; $display("FAIL gdrop_first_write: got none want write"); end
        bus_gnt = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (bus_req !== 1'b1 || mem_w !== 1'b0 || addr_bus !== 32'h0 || data2bus !== 32'h0) begin
                bad++; $display("FAIL gdrop_stall%0d: got req=%b w=%b a=%h d=%h want 1 0 0 0", c, bus_req, mem_w, addr_bus, data2bus);
            end
        end
        bus_gnt = 1'b1;
        for (int t = 0; t < 50; t++) begin
            if (done) break;
            @(negedge clk);
        end
        @(negedge clk);
        total++; if (done_cnt != dc + 1) begin bad++; $display("FAIL gdrop_done: got %0d pulses want 1", done_cnt - dc); end
        total++; if (mem_rd(32'h120) !== 32'h1234_5678 || mem_rd(32'h124) !== 32'h9ABC_DEF0) begin
            bad++; $display("FAIL gdrop_mem: got %h %h want 12345678 9abcdef0", mem_rd(32'h120), mem_rd(32'h124));
        end
    endtask

    task automatic test_back_to_back();
        int k, da; logic e;
        for (int i = 0; i < 4; i++) mem[32'h60 + 32'(4 * i)] = 32'h6000_0000 + 32'(i);
        run_xfer(32'h60, 32'h160, 8'd4, 1, 1, 0, 1, k, da, e);
        total++; if (da !== k + 2 + 4 * (LAT + 1)) begin bad++; $display("FAIL b2b_done_cycle: got %0d want %0d", da - k, 2 + 4 * (LAT + 1)); end
        total++; if (wq_a.size() != 4) begin bad++; $display("FAIL b2b_nwrites: got %0d want 4", wq_a.size()); end
        for (int i = 0; i < 4 && i < wq_a.size(); i++) begin
            total++;
            if (wq_a[i] !== ex_a[i] || wq_d[i] !== ex_d[i]) begin
                bad++; $display("FAIL b2b_write%0d: got %h<=%h want %h<=%h", i, wq_a[i], wq_d[i], ex_a[i], ex_d[i]);
            end
        end
        // A start in the done cycle must be dropped.
        src_addr = 32'h60; dst_addr = 32'h180; len = 8'd1; src_inc = 1; dst_inc = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL b2b_start_in_done: got busy=%b req=%b want 0 0", busy, bus_req); end
        mem[32'h70] = 32'h7777_0001; mem[32'h74] = 32'h7777_0002;
        run_xfer(32'h70, 32'h170, 8'd2, 1, 1, 0, 0, k, da, e);
        total++; if (wq_a.size() != 2 || wq_d[0] !== 32'h7777_0001 || wq_a[1] !== 32'h174) begin
            bad++; $display("FAIL b2b_second: got n=%0d", wq_a.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int k, da, dc, nw; logic e;
        bit found = 0;
        mem[32'h200] = 32'h2000_00A0; mem[32'h204] = 32'h2000_00A1; mem[32'h208] = 32'h2000_00A2;
        @(negedge clk);
        src_addr = 32'h200; dst_addr = 32'h400; len = 8'd3; src_inc = 1; dst_inc = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (bus_req && !mem_w && addr_bus == 32'h204) begin found = 1; break; end
            @(negedge clk);
        end
        total++; if (!found) begin bad++; $display("FAIL rmid_reach_rd2: got none want rd 204"); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({busy, done, err, bus_req, mem_w} !== 5'b0 || addr_bus !== 32'h0 || data2bus !== 32'h0) begin
            bad++; $display("FAIL rmid_outputs: got b=%b r=%b w=%b a=%h d=%h want all 0", busy, bus_req, mem_w, addr_bus, data2bus);
        end
        dc = done_cnt; nw = wq_a.size();
        repeat (4) @(negedge clk);
        total++; if (done_cnt != dc || wq_a.size() != nw) begin bad++; $display("FAIL rmid_quiet: got done=%0d writes=%0d want 0 0", done_cnt - dc, wq_a.size() - nw); end
        rst_n = 1'b1;
        run_xfer(32'h200, 32'h500, 8'd3, 1, 1, 0, 0, k, da, e);
        total++; if (da !== k + 2 + 3 * (LAT + 1)) begin bad++; $display("FAIL rmid_clean_cycle: got %0d want %0d", da - k, 2 + 3 * (LAT + 1)); end
        total++; if (mem_rd(32'h500) !== 32'h2000_00A0 || mem_rd(32'h504) !== 32'h2000_00A1 || mem_rd(32'h508) !== 32'h2000_00A2) begin
            bad++; $display("FAIL rmid_clean_mem: got %h %h %h", mem_rd(32'h500), mem_rd(32'h504), mem_rd(32'h508));
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int k, da, dc; logic e;
        logic [31:0] s, d;
        logic [7:0] n;
        logic si, di;
        bit rg;
        for (int i = 0; i < 64; i++) mem[32'h1000 + 32'(4 * i)] = $urandom;
        for (int it = 0; it < 8; it++) begin
            s  = 32'h1000 + 32'($urandom_range(0, 40) * 4);
            d  = 32'h8000 + 32'($urandom_range(0, 40) * 4);
            n  = 8'($urandom_range(1, 12));
            si = 1'($urandom_range(0, 1));
            di = 1'($urandom_range(0, 1));
            rg = (it % 2) == 1;
            dc = done_cnt;
            run_xfer(s, d, n, si, di, rg, 0, k, da, e);
            @(negedge clk);
            total++; if (done_cnt != dc + 1 || e !== 1'b0) begin bad++; $display("FAIL rand%0d_done: got pulses=%0d err=%b want 1 0", it, done_cnt - dc, e); end
            if (!rg) begin
                total++; if (da !== k + 2 + int'(n) * (LAT + 1)) begin bad++; $display("FAIL rand%0d_cycle: got %0d want %0d", it, da - k, 2 + int'(n) * (LAT + 1)); end
            end
            total++; if (wq_a.size() != ex_a.size()) begin bad++; $display("FAIL rand%0d_nwrites: got %0d want %0d", it, wq_a.size(), ex_a.size()); end
            for (int j = 0; j < ex_a.size() && j < wq_a.size(); j++) begin
                total++;
                if (wq_a[j] !== ex_a[j] || wq_d[j] !== ex_d[j]) begin
                    bad++; $display("FAIL rand%0d_write%0d: got %h<=%h want %h<=%h", it, j, wq_a[j], wq_d[j], ex_a[j], ex_d[j]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_misaligned();
        test_fixed_dst();
        test_grant_drop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
